cla_pipe_adder: RTL and testbench



---
 rtl/cla_pipe_adder_if.sv | 26 ++
 rtl/cla_pipe_adder.sv | 104 ++++++++++
 tb/tb_cla_pipe_adder.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle for cla_pipe_adder: operand beat in, result beat out.
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor, one BLK-bit group per stage, WIDTH/BLK register stages.
// One global enable: the whole pipe holds while a result is stalled; in_ready = ~out_valid | out_ready.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_adder_if.slave bus
);
  localparam int NBLK = WIDTH / BLK;

  if (WIDTH % BLK != 0) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of BLK");
  end

  // Flattened sum-of-products lookahead: every carry depends only on p, g and the group carry-in.
  function automatic logic [BLK:0] lookahead(input logic [BLK-1:0] p,
                                             input logic [BLK-1:0] g,
                                             input logic           c0);
    logic [BLK:0] c;
    logic         term;
    logic         prop;
    c    = '0;
    c[0] = c0;
    for (int i = 0; i < BLK; i++) begin
      term = g[i];
      prop = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (prop & g[j]);
        prop = prop & p[j];
      end
      c[i+1] = term | (prop & c0);
    end
    return c;
  endfunction

  // Operand words shift right each stage so the group being added always sits at the LSBs;
  // the result word shifts right too, each stage inserting its slice at the top.
  logic [WIDTH-1:0] a_q  [NBLK];
  logic [WIDTH-1:0] b_q  [NBLK];
  logic [WIDTH-1:0] s_q  [NBLK];
  logic [NBLK-1:0]  v_q;
  logic [NBLK-1:0]  co_q;
  logic             cm_q;

  logic [WIDTH-1:0] a_st [NBLK];
  logic [WIDTH-1:0] b_st [NBLK];
  logic [WIDTH-1:0] s_st [NBLK];
  logic [NBLK-1:0]  v_st;
  logic [NBLK-1:0]  c_st;
  logic [BLK:0]     cy    [NBLK];
  logic [BLK-1:0]   grp_s [NBLK];
  logic             en;

  always_comb begin
    a_st[0] = bus.a;
    b_st[0] = bus.sub ? ~bus.b : bus.b;
    c_st[0] = bus.sub | bus.cin;
    v_st[0] = bus.in_valid;
    s_st[0] = '0;
    for (int k = 1; k < NBLK; k++) begin
      a_st[k] = a_q[k-1];
      b_st[k] = b_q[k-1];
      c_st[k] = co_q[k-1];
      v_st[k] = v_q[k-1];
      s_st[k] = s_q[k-1];
    end
    for (int k = 0; k < NBLK; k++) begin
      cy[k]    = lookahead(a_st[k][BLK-1:0] ^ b_st[k][BLK-1:0],
                           a_st[k][BLK-1:0] & b_st[k][BLK-1:0], c_st[k]);
      grp_s[k] = a_st[k][BLK-1:0] ^ b_st[k][BLK-1:0] ^ cy[k][BLK-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NBLK; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      v_q  <= '0;
      co_q <= '0;
      cm_q <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < NBLK; k++) begin
        a_q[k]  <= a_st[k] >> BLK;
        b_q[k]  <= b_st[k] >> BLK;
        s_q[k]  <= (s_st[k] >> BLK) | (WIDTH'(grp_s[k]) << (WIDTH - BLK));
        co_q[k] <= cy[k][BLK];
      end
      v_q  <= v_st;
      cm_q <= cy[NBLK-1][BLK-1];
    end
  end

  assign en            = ~v_q[NBLK-1] | bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v_q[NBLK-1];
  assign bus.sum       = s_q[NBLK-1];
  assign bus.cout      = co_q[NBLK-1];
  assign bus.ovf       = cm_q ^ co_q[NBLK-1];
endmodule

// File: tb/tb_cla_pipe_adder.sv
// Drives 16/4, 32/8 and 12/3 adders in lockstep and checks every result against an integer model.
module tb_cla_pipe_adder;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cla_pipe_adder_if #(.WIDTH(16)) b16 ();
  cla_pipe_adder_if #(.WIDTH(32)) b32 ();
  cla_pipe_adder_if #(.WIDTH(12)) b12 ();

  cla_pipe_adder #(.WIDTH(16), .BLK(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  cla_pipe_adder #(.WIDTH(32), .BLK(8)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  cla_pipe_adder #(.WIDTH(12), .BLK(3)) dut12 (.clk(clk), .rst(rst), .bus(b12));

  logic [63:0] o_sum [3];
  logic        o_vld [3];
  logic        o_rdy [3];
  logic        o_co  [3];
  logic        o_ov  [3];

  assign o_sum[0] = 64'(b16.sum);
  assign o_sum[1] = 64'(b32.sum);
  assign o_sum[2] = 64'(b12.sum);
  assign o_vld[0] = b16.out_valid;
  assign o_vld[1] = b32.out_valid;
  assign o_vld[2] = b12.out_valid;
  assign o_rdy[0] = b16.in_ready;
  assign o_rdy[1] = b32.in_ready;
  assign o_rdy[2] = b12.in_ready;
  assign o_co[0]  = b16.cout;
  assign o_co[1]  = b32.cout;
  assign o_co[2]  = b12.cout;
  assign o_ov[0]  = b16.ovf;
  assign o_ov[1]  = b32.ovf;
  assign o_ov[2]  = b12.ovf;

  // Expected-result FIFOs per DUT, plus last-seen outputs for stall stability.
  logic [63:0] e_s [3][64];
  logic        e_c [3][64];
  logic        e_o [3][64];
  int          wr  [3];
  int          rd  [3];
  logic        stall_p [3];
  logic [63:0] p_s [3];
  logic        p_c [3];
  logic        p_o [3];
  logic        samp_vld [3];
  int          lat [3];
  logic        got16;
  logic [63:0] g_s;
  logic        g_c;
  logic        g_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $fatal(1, "FAIL watchdog timeout");
  end

  function automatic int wd(input int d);
    case (d)
      0:       return 16;
      1:       return 32;
      default: return 12;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned view gives sum/cout, signed view gives overflow.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic is_sub,
                       output logic [63:0] s, output logic co, output logic ov);
    longint lim, ua, ub, sa, sbv, ur, sr;
    lim = longint'(1) << w;
    ua  = longint'(a) & (lim - 1);
    ub  = longint'(b) & (lim - 1);
    sa  = (ua >= lim / 2) ? ua - lim : ua;
    sbv = (ub >= lim / 2) ? ub - lim : ub;
    if (is_sub) begin
      ur = ua - ub;
      co = (ua >= ub);
      sr = sa - sbv;
    end else begin
      ur = ua + ub + longint'(ci);
      co = (ur >= lim);
      sr = sa + sbv + longint'(ci);
    end
    s  = 64'(ur & (lim - 1));
    ov = (sr >= lim / 2) || (sr < -(lim / 2));
  endtask

  task automatic drive(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic is_sub, input logic orr);
    b16.in_valid = iv; b16.a = a[15:0]; b16.b = b[15:0]; b16.cin = ci; b16.sub = is_sub; b16.out_ready = orr;
    b32.in_valid = iv; b32.a = a[31:0]; b32.b = b[31:0]; b32.cin = ci; b32.sub = is_sub; b32.out_ready = orr;
    b12.in_valid = iv; b12.a = a[11:0]; b12.b = b[11:0]; b12.cin = ci; b12.sub = is_sub; b12.out_ready = orr;
  endtask

  // One clock: drive after the falling edge, check/score mid-low-phase, then let the rising edge happen.
  task automatic cycle(input logic iv, input logic [63:0] a, input logic [63:0] b,
                       input logic ci, input logic is_sub, input logic orr);
    logic [63:0] ms;
    logic        mc;
    logic        mo;
    int          idx;
    @(negedge clk);
    drive(iv, a, b, ci, is_sub, orr);
    #1;
    for (int d = 0; d < 3; d++) begin
      samp_vld[d] = o_vld[d];
      chk($sformatf("in_ready_w%0d", wd(d)), 64'(o_rdy[d]), 64'(!o_vld[d] || orr));
      if (stall_p[d]) begin
        chk($sformatf("hold_valid_w%0d", wd(d)), 64'(o_vld[d]), 64'd1);
        chk($sformatf("hold_sum_w%0d", wd(d)), o_sum[d], p_s[d]);
        chk($sformatf("hold_cout_w%0d", wd(d)), 64'(o_co[d]), 64'(p_c[d]));
        chk($sformatf("hold_ovf_w%0d", wd(d)), 64'(o_ov[d]), 64'(p_o[d]));
      end
      if (o_vld[d] && orr) begin
        chk($sformatf("beat_pending_w%0d", wd(d)), 64'(wr[d] > rd[d]), 64'd1);
        if (wr[d] > rd[d]) begin
          idx = rd[d] % 64;
          chk($sformatf("sum_w%0d", wd(d)), o_sum[d], e_s[d][idx]);
          chk($sformatf("cout_w%0d", wd(d)), 64'(o_co[d]), 64'(e_c[d][idx]));
          chk($sformatf("ovf_w%0d", wd(d)), 64'(o_ov[d]), 64'(e_o[d][idx]));
          rd[d]++;
        end
        if (d == 0) begin
          got16 = 1'b1;
          g_s   = o_sum[0];
          g_c   = o_co[0];
          g_o   = o_ov[0];
        end
      end
      if (iv && o_rdy[d]) begin
        model(wd(d), a, b, ci, is_sub, ms, mc, mo);
        idx         = wr[d] % 64;
        e_s[d][idx] = ms;
        e_c[d][idx] = mc;
        e_o[d][idx] = mo;
        wr[d]++;
      end
      stall_p[d] = o_vld[d] && !orr;
      p_s[d]     = o_sum[d];
      p_c[d]     = o_co[d];
      p_o[d]     = o_ov[d];
    end
    @(posedge clk);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic is_sub,
                          input logic [15:0] es, input logic ec, input logic eo);
    got16 = 1'b0;
    cycle(1'b1, 64'(a), 64'(b), ci, is_sub, 1'b1);
    for (int n = 0; n < 10 && !got16; n++) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk({tag, "_seen"}, 64'(got16), 64'd1);
    chk({tag, "_sum"}, g_s, 64'(es));
    chk({tag, "_cout"}, 64'(g_c), 64'(ec));
    chk({tag, "_ovf"}, 64'(g_o), 64'(eo));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    got16  = 1'b0;
    g_s    = '0;
    g_c    = 1'b0;
    g_o    = 1'b0;
    rst    = 1'b1;
    for (int d = 0; d < 3; d++) begin
      wr[d] = 0; rd[d] = 0; stall_p[d] = 1'b0; samp_vld[d] = 1'b0; lat[d] = 0;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_valid_w%0d", wd(d)), 64'(o_vld[d]), 64'd0);
      chk($sformatf("reset_sum_w%0d", wd(d)), o_sum[d], 64'd0);
      chk($sformatf("reset_cout_w%0d", wd(d)), 64'(o_co[d]), 64'd0);
      chk($sformatf("reset_ovf_w%0d", wd(d)), 64'(o_ov[d]), 64'd0);
      chk($sformatf("reset_ready_w%0d", wd(d)), 64'(o_rdy[d]), 64'd1);
    end

    directed("carry_all",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("ovf_pos",      16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("ovf_neg",      16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_borrow",   16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    directed("cin_add",      16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed("sub_min",      16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);

    // Back-to-back stream: once primed, a result must be present every cycle.
    for (int i = 0; i < 1004; i++) begin
      cycle(1'(i < 1000), rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'b1);
      if (i >= 4) begin
        for (int d = 0; d < 3; d++) chk($sformatf("stream_valid_w%0d", wd(d)), 64'(samp_vld[d]), 64'd1);
      end
    end

    for (int i = 0; i < 800; i++) begin
      cycle(1'($urandom_range(0, 3) != 0), rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    repeat (12) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    for (int d = 0; d < 3; d++) chk($sformatf("no_loss_w%0d", wd(d)), 64'(wr[d] - rd[d]), 64'd0);

    // Three beats in flight, the oldest already presented and stalled, then reset mid-cycle.
    cycle(1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_1111, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'b1);
    cycle(1'b1, rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'b1);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("pre_rst_valid_w%0d", wd(d)), 64'(o_vld[d]), 64'd1);
    rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid_w%0d", wd(d)), 64'(o_vld[d]), 64'd0);
      chk($sformatf("rst_sum_w%0d", wd(d)), o_sum[d], 64'd0);
      chk($sformatf("rst_cout_w%0d", wd(d)), 64'(o_co[d]), 64'd0);
      chk($sformatf("rst_ovf_w%0d", wd(d)), 64'(o_ov[d]), 64'd0);
      rd[d]      = wr[d];
      stall_p[d] = 1'b0;
      lat[d]     = 0;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    cycle(1'b1, rnd64(), rnd64(), 1'($urandom), 1'($urandom), 1'b1);
    for (int n = 1; n <= 12; n++) begin
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      for (int d = 0; d < 3; d++) if (samp_vld[d] && lat[d] == 0) lat[d] = n;
    end
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_latency_w%0d", wd(d)), 64'(lat[d]), 64'd4);
      chk($sformatf("post_rst_drained_w%0d", wd(d)), 64'(wr[d] - rd[d]), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
